run_length_detector: RTL and testbench
======================================

# run_length_detector

Parametrised multi-channel run-length detector: each channel tracks consecutive 1-samples on its serial input with a saturating run counter. Per channel it provides:
- a Moore match flag when the run length equals a programmable value;
- a saturation flag;
- a count of how many times the run reached saturation.

It generalises the team's fixed three-state "one-then-more" sequence FSM to arbitrary run lengths, match points and channel counts. It also adds enable, synchronous clear and event counting.

## Interface
- CH, default 1: number of independent channels, ≥1
- RUN_LEN, default 2: run-counter saturation value, ≥1
- MATCH, default 1: run value that asserts q, 1 ≤ MATCH ≤ RUN_LEN
- EVT_W, default 8: width of each event counter, ≥1
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  sample enable; when low all state holds
- clr  input  1  synchronous clear of run counters and event counters
- i  input  CH  serial data, one bit per channel
- q  output  CH  q[c] = 1 iff run[c] == MATCH (Moore, from registered state)
- sat  output  CH  sat[c] = 1 iff run[c] == RUN_LEN
- evt_cnt  output  CH×EVT_W  per-channel count of entries into saturation, packed channel 0 in LSBs

## Operation
- Per-channel state: run[c], width RUN_W = $clog2(RUN_LEN+1), range 0..RUN_LEN. Per-channel evt[c], width EVT_W.
- Per rising clk edge, in priority order:
  1. clr=1: run[c] ← 0 and evt[c] ← 0 for all c, regardless of en.
  2. en=0: hold everything.
  3. en=1, i[c]=0: run[c] ← 0.
  4. en=1, i[c]=1: run[c] ← min(run[c]+1, RUN_LEN).
- Event counting: evt[c] increments when run[c] == RUN_LEN-1, en=1, i[c]=1 and clr=0, i.e. the cycle run enters saturation.
  - Once per run; staying saturated does not re-count.
  - evt[c] saturates at 2^EVT_W−1; no wrap.
  - RUN_LEN=1: the entry condition is run==0 and i=1.
- Outputs are purely decoded from registered state. No combinational path from i, en or clr to any output.
- Defaults (CH=1, RUN_LEN=2, MATCH=1) reproduce the existing three-state detector: q high exactly one cycle after the first 1 of a run.
- Channels are fully independent; only en, clr and reset are shared.

## Timing
- Reset (async assert, sync-safe deassert by integration): run=0, evt=0, so q=0, sat=0, evt_cnt=0 immediately on assertion, without waiting for clk.
- Reset mid-run: state cleared instantly; the first sample after release starts a new run at 0.
- Latency: a 1-sample on i at edge k makes run visible after edge k; q rises at edge k+MATCH−1 of a run whose first 1 was sampled at edge k.
- sat rises the edge run reaches RUN_LEN and evt_cnt updates on that same edge.
- A 0 sample drops q and sat on the next edge, except that q stays 0 if already 0.
- en low for n cycles stretches a run without breaking it; the run continues when en returns.
- clr and en=1 same cycle: clr wins, run=0, no event counted even if saturation would be entered.

## Structure
- Shared package run_det_pkg holds:
  - the RUN_W width function, or a clog2 wrapper;
  - the parameter-legality checks (elaboration-time $error if MATCH>RUN_LEN or RUN_LEN<1).
- Sub-module run_det_chan implements one channel: run counter, event counter and decodes, with the same parameters minus CH.
- Top level is a generate loop of CH instances plus output packing.

## Test plan
- Defaults, i=0,1,1,1,0,1,0: q=0,1,0,0,0,1,0 (one cycle after each sample); sat=0,0,1,1,0,0,0; evt_cnt ends at 1.
- RUN_LEN=4, MATCH=3, i=1×6: q high only after the 3rd 1; sat from the 4th on; evt_cnt=1. Repeating after a single 0 gives evt_cnt=2.
- en stretch: RUN_LEN=3, i=1,1 then en=0 for 5 cycles with i=0, then en=1 and i=1: sat asserts after that sample; run not broken.
- clr during entry: RUN_LEN=2 with run=1, apply i=1, en=1, clr=1: run=0, sat=0, evt_cnt=0.
- EVT_W=2, RUN_LEN=1, i alternating 1,0 ×6: evt_cnt reaches 3 and holds at 3.
- CH=4, independent patterns per channel, async reset pulse mid-stream between edges: all outputs 0 immediately; each channel matches a scoreboard model afterwards.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared helpers for the run-length detector: run counter width and
// parameter legality, used by the top level and every channel.
package run_det_pkg;

    function automatic int run_w(input int run_len);
        return (run_len < 1) ? 1 : $clog2(run_len + 1);
    endfunction

    function automatic bit params_ok(input int ch, input int run_len,
                                     input int match, input int evt_w);
        return (ch >= 1) && (run_len >= 1) && (match >= 1) &&
               (match <= run_len) && (evt_w >= 1);
    endfunction

endpackage

// File: rtl/run_det_chan.sv
// One detector channel: saturating run counter, saturation-entry event
// counter, and the match/saturation decodes taken straight from state.
module run_det_chan
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int MATCH   = 1,
    parameter int EVT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             i,
    output logic             q,
    output logic             sat,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int RUN_W = run_w(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(RUN_LEN - 1);
    localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(MATCH);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic [RUN_W-1:0] run;
    logic [EVT_W-1:0] evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= '0;
            evt <= '0;
        end else if (clr) begin
            run <= '0;
            evt <= '0;
        end else if (en) begin
            if (!i)
                run <= '0;
            else if (run != RUN_MAX)
                run <= run + 1'b1;
            // Counting only the step from RUN_LEN-1 makes a held saturation count once.
            if (i && (run == RUN_PRE) && (evt != EVT_MAX))
                evt <= evt + 1'b1;
        end
    end

    assign q       = (run == RUN_HIT);
    assign sat     = (run == RUN_MAX);
    assign evt_cnt = evt;

endmodule

// File: rtl/run_length_detector.sv
// Multi-channel run-length detector: CH independent channels sharing
// enable, synchronous clear and asynchronous reset.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int CH      = 1,
    parameter int RUN_LEN = 2,
    parameter int MATCH   = 1,
    parameter int EVT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic [CH-1:0]       i,
    output logic [CH-1:0]       q,
    output logic [CH-1:0]       sat,
    output logic [CH*EVT_W-1:0] evt_cnt
);

    if (!params_ok(CH, RUN_LEN, MATCH, EVT_W)) begin : g_bad_params
        $error("run_length_detector: illegal parameters CH=%0d RUN_LEN=%0d MATCH=%0d EVT_W=%0d",
               CH, RUN_LEN, MATCH, EVT_W);
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        run_det_chan #(
            .RUN_LEN (RUN_LEN),
            .MATCH   (MATCH),
            .EVT_W   (EVT_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .clr     (clr),
            .i       (i[c]),
            .q       (q[c]),
            .sat     (sat[c]),
            .evt_cnt (evt_cnt[c*EVT_W +: EVT_W])
        );
    end

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: four parameter sets driven in lockstep,
// checked every cycle against a run-length model plus literal expectations.
module tb_run_length_detector;

    logic clk = 1'b0;
    logic reset, en, clr;
    logic [3:0]  ia;
    logic [0:0]  ib;
    logic [1:0]  ic;
    logic [0:0]  id;
    logic [3:0]  qa, sata;
    logic [11:0] evta;
    logic [0:0]  qb, satb;
    logic [7:0]  evtb;
    logic [1:0]  qc, satc;
    logic [3:0]  evtc;
    logic [0:0]  qd, satd;
    logic [3:0]  evtd;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    int run_a[4], evt_a[4], run_c[2], evt_c[2];
    int run_b, evt_b, run_d, evt_d;

    always #5 clk = ~clk;

    run_length_detector #(.CH(4), .RUN_LEN(4), .MATCH(3), .EVT_W(3)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .i(ia),
        .q(qa), .sat(sata), .evt_cnt(evta));
    run_length_detector #(.CH(1), .RUN_LEN(2), .MATCH(1), .EVT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .i(ib),
        .q(qb), .sat(satb), .evt_cnt(evtb));
    run_length_detector #(.CH(2), .RUN_LEN(1), .MATCH(1), .EVT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .i(ic),
        .q(qc), .sat(satc), .evt_cnt(evtc));
    run_length_detector #(.CH(1), .RUN_LEN(3), .MATCH(2), .EVT_W(4)) dut_d (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .i(id),
        .q(qd), .sat(satd), .evt_cnt(evtd));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run length after one enabled sample: a 0 breaks the run, a 1 extends it up to the cap.
    function automatic int nrun(input int r, input logic b, input int rl);
        if (b !== 1'b1) return 0;
        return (r >= rl) ? rl : r + 1;
    endfunction

    // An event is the run arriving at the cap from below; the counter sticks at its maximum.
    function automatic int nevt(input int r, input int nr, input int e, input int rl, input int w);
        if (nr == rl && r < rl) return (e >= (1 << w) - 1) ? e : e + 1;
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin run_a[c] = 0; evt_a[c] = 0; end
        for (int c = 0; c < 2; c++) begin run_c[c] = 0; evt_c[c] = 0; end
        run_b = 0; evt_b = 0; run_d = 0; evt_d = 0;
    endtask

    task automatic model_edge();
        int nr;
        if (clr) model_reset();
        else if (en) begin
            for (int c = 0; c < 4; c++) begin
                nr = nrun(run_a[c], ia[c], 4);
                evt_a[c] = nevt(run_a[c], nr, evt_a[c], 4, 3);
                run_a[c] = nr;
            end
            for (int c = 0; c < 2; c++) begin
                nr = nrun(run_c[c], ic[c], 1);
                evt_c[c] = nevt(run_c[c], nr, evt_c[c], 1, 2);
                run_c[c] = nr;
            end
            nr = nrun(run_b, ib[0], 2);
            evt_b = nevt(run_b, nr, evt_b, 2, 8);
            run_b = nr;
            nr = nrun(run_d, id[0], 3);
            evt_d = nevt(run_d, nr, evt_d, 3, 4);
            run_d = nr;
        end
    endtask

    task automatic compare_all();
        logic [3:0]  qe_a, se_a;
        logic [11:0] ee_a;
        logic [1:0]  qe_c, se_c;
        logic [3:0]  ee_c;
        for (int c = 0; c < 4; c++) begin
            qe_a[c] = (run_a[c] == 3);
            se_a[c] = (run_a[c] == 4);
            ee_a[c*3 +: 3] = 3'(evt_a[c]);
        end
        for (int c = 0; c < 2; c++) begin
            qe_c[c] = (run_c[c] == 1);
            se_c[c] = (run_c[c] == 1);
            ee_c[c*2 +: 2] = 2'(evt_c[c]);
        end
        chk("A.q",   64'(qa),   64'(qe_a));
        chk("A.sat", 64'(sata), 64'(se_a));
        chk("A.evt", 64'(evta), 64'(ee_a));
        chk("B.q",   64'(qb),   64'(run_b == 1));
        chk("B.sat", 64'(satb), 64'(run_b == 2));
        chk("B.evt", 64'(evtb), 64'(evt_b));
        chk("C.q",   64'(qc),   64'(qe_c));
        chk("C.sat", 64'(satc), 64'(se_c));
        chk("C.evt", 64'(evtc), 64'(ee_c));
        chk("D.q",   64'(qd),   64'(run_d == 2));
        chk("D.sat", 64'(satd), 64'(run_d == 3));
        chk("D.evt", 64'(evtd), 64'(evt_d));
    endtask

    always @(negedge clk) if (chk_on && !reset) compare_all();

    task automatic check_zero(input string tag);
        chk({tag, ".A.q"}, 64'(qa), 64'd0);   chk({tag, ".A.sat"}, 64'(sata), 64'd0);
        chk({tag, ".A.evt"}, 64'(evta), 64'd0);
        chk({tag, ".B.q"}, 64'(qb), 64'd0);   chk({tag, ".B.sat"}, 64'(satb), 64'd0);
        chk({tag, ".B.evt"}, 64'(evtb), 64'd0);
        chk({tag, ".C.q"}, 64'(qc), 64'd0);   chk({tag, ".C.sat"}, 64'(satc), 64'd0);
        chk({tag, ".C.evt"}, 64'(evtc), 64'd0);
        chk({tag, ".D.q"}, 64'(qd), 64'd0);   chk({tag, ".D.sat"}, 64'(satd), 64'd0);
        chk({tag, ".D.evt"}, 64'(evtd), 64'd0);
    endtask

    // Inputs change only after a falling edge; the model advances on the rising edge.
    task automatic step(input logic e, input logic c, input logic [3:0] a,
                        input logic b, input logic [1:0] cc, input logic d);
        en = e; clr = c; ia = a; ib[0] = b; ic = cc; id[0] = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    bit pa0[12] = '{1,1,1,1,1,1,0,1,1,1,1,0};
    bit pa1[12] = '{1,0,1,1,0,1,1,1,0,0,1,1};
    bit pa2[12] = '{0,0,0,1,1,1,1,1,1,1,0,1};
    bit pa3[12] = '{1,1,0,1,1,1,0,1,1,1,1,1};
    bit pb[12]  = '{0,1,1,1,0,1,0,0,0,0,0,0};
    bit pc0[12] = '{1,0,1,0,1,0,1,0,1,0,1,0};
    bit pc1[12] = '{1,1,1,0,1,1,0,0,1,1,1,1};
    bit pd[12]  = '{1,1,1,1,0,0,1,1,1,0,1,0};
    bit qlit_b[7] = '{0,1,0,0,0,1,0};
    bit slit_b[7] = '{0,0,1,1,0,0,0};

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0;
        ia = '0; ib = '0; ic = '0; id = '0;
        model_reset();
        #1;
        check_zero("rst0");
        @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;

        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, {pa3[k], pa2[k], pa1[k], pa0[k]}, pb[k], {pc1[k], pc0[k]}, pd[k]);
            if (k < 7) begin
                chk("B.q literal",   64'(qb),   64'(qlit_b[k]));
                chk("B.sat literal", 64'(satb), 64'(slit_b[k]));
            end
            if (k == 2) chk("A0.q third one",  64'(qa[0]), 64'd1);
            if (k == 3) chk("A0.q fourth one", 64'(qa[0]), 64'd0);
        end
        chk("B.evt literal",  64'(evtb),      64'd1);
        chk("A0.evt literal", 64'(evta[2:0]), 64'd2);
        chk("C0.evt held",    64'(evtc[1:0]), 64'd3);

        step(1'b1, 1'b0, 4'hF, 1'b1, 2'b11, 1'b1);
        step(1'b1, 1'b0, 4'hF, 1'b1, 2'b11, 1'b1);
        chk("D.q before stall", 64'(qd), 64'd1);
        repeat (5) step(1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("D.sat during stall", 64'(satd), 64'd0);
        step(1'b1, 1'b0, 4'hF, 1'b1, 2'b11, 1'b1);
        chk("D.sat after stall", 64'(satd), 64'd1);
        chk("D.evt after stall", 64'(evtd), 64'd3);
        chk("D.q after stall",   64'(qd),   64'd0);

        step(1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b1, 2'b00, 1'b0);
        chk("B.q run one", 64'(qb), 64'd1);
        step(1'b1, 1'b1, 4'hF, 1'b1, 2'b11, 1'b1);
        chk("clr B.sat", 64'(satb), 64'd0);
        chk("clr B.q",   64'(qb),   64'd0);
        chk("clr B.evt", 64'(evtb), 64'd0);
        chk("clr A.evt", 64'(evta), 64'd0);
        chk("clr C.evt", 64'(evtc), 64'd0);

        repeat (12) step(1'($urandom_range(0, 3) != 0), 1'b0, 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));
        #1 reset = 1'b1;
        #1 check_zero("rst_mid");
        model_reset();
        #1 reset = 1'b0;
        repeat (30) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
